// File: rtl/flit_injector_pkg.sv
// Shared types for the flit injector: flit layout, head-field packing and FSM states.
package flit_injector_pkg;

  localparam int FLIT_DATA_W = 32;
  localparam int PKG_MAX_LEN = 16;
  localparam int PKG_LEN_W   = $clog2(PKG_MAX_LEN + 1);
  localparam int ADDR_W      = 4;

  typedef logic [ADDR_W-1:0] PORT_ADDR_t;

  typedef enum logic [1:0] {
    FT_HEAD     = 2'd0,
    FT_BODY     = 2'd1,
    FT_TAIL     = 2'd2,
    FT_HEADTAIL = 2'd3
  } FLIT_TYPE_t;

  // Packed into the low bits of a head flit's data field.
  typedef struct packed {
    PORT_ADDR_t           dest;
    PORT_ADDR_t           src;
    logic [PKG_LEN_W-1:0] len;
  } HEAD_INFO_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HEAD = 2'd1,
    S_BODY = 2'd2,
    S_LAST = 2'd3
  } INJ_STATE_t;

  typedef struct packed {
    FLIT_TYPE_t             ftype;
    logic [FLIT_DATA_W-1:0] data;
  } FLIT_t;

endpackage

// File: rtl/flit_injector_out_reg.sv
// Output holding register: keeps the flit and req stable until the router takes it.
module flit_injector_out_reg
  import flit_injector_pkg::*;
(
  input  logic  clk,
  input  logic  reset_n,
  input  logic  load,
  input  FLIT_t load_flit,
  input  logic  on_off,
  output logic  can_load,
  output FLIT_t flit,
  output logic  req
);

  // Empty, or its current flit leaves on this edge.
  assign can_load = !req || on_off;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flit <= '0;
      req  <= 1'b0;
    end else if (load && can_load) begin
      flit <= load_flit;
      req  <= 1'b1;
    end else if (req && on_off) begin
      req  <= 1'b0;
    end
  end

endmodule

// File: rtl/flit_injector.sv
// Source-side network interface: segments a descriptor plus payload into HEAD/BODY/TAIL flits.
module flit_injector
  import flit_injector_pkg::*;
#(
  parameter int         DATA_W   = FLIT_DATA_W,
  parameter int         MAX_LEN  = PKG_MAX_LEN,
  parameter int         LEN_W    = $clog2(MAX_LEN + 1),
  parameter PORT_ADDR_t SRC_ADDR = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_pkt_valid,
  output logic              o_pkt_ready,
  input  PORT_ADDR_t        i_pkt_dest,
  input  logic [LEN_W-1:0]  i_pkt_len,
  input  logic              i_data_valid,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_data_ready,
  output FLIT_t             o_flit,
  output logic              o_upstream_req,
  input  logic              i_on_off,
  output logic              o_busy,
  output logic [15:0]       o_pkt_sent,
  output INJ_STATE_t        o_state
);

  // Handshakes: descriptor and payload words move on a rising edge with valid&ready
  // (ready never depends on valid); a flit moves on a rising edge with o_upstream_req&i_on_off.

  INJ_STATE_t       state, state_nx;
  logic [LEN_W-1:0] rem_q;
  logic [LEN_W-1:0] len_c;
  logic [15:0]      sent_q;
  logic             rdy_en;
  logic             load, can_load, xfer, word_ok, sent_inc;
  FLIT_t            load_flit;
  HEAD_INFO_t       head_info;

  assign len_c = (i_pkt_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : i_pkt_len;
  assign head_info = '{dest: i_pkt_dest, src: SRC_ADDR, len: PKG_LEN_W'(len_c)};
  assign xfer = o_upstream_req && i_on_off;

  flit_injector_out_reg u_out_reg (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (load),
    .load_flit (load_flit),
    .on_off    (i_on_off),
    .can_load  (can_load),
    .flit      (o_flit),
    .req       (o_upstream_req)
  );

  always_comb begin
    state_nx     = state;
    load         = 1'b0;
    load_flit    = '0;
    o_pkt_ready  = 1'b0;
    o_data_ready = 1'b0;
    sent_inc     = 1'b0;
    word_ok      = 1'b0;
    case (state)
      S_IDLE: begin
        o_pkt_ready = rdy_en;
        if (rdy_en && i_pkt_valid) begin
          load            = 1'b1;
          load_flit.ftype = (len_c == '0) ? FT_HEADTAIL : FT_HEAD;
          load_flit.data  = FLIT_DATA_W'(head_info);
          state_nx        = S_HEAD;
        end
      end
      S_HEAD: begin
        // The first word may load while the head leaves, so HEAD/BODY go out back to back.
        o_data_ready = (rem_q != '0) && can_load;
        if (xfer) begin
          if (rem_q == '0) begin
            state_nx = S_IDLE;
            sent_inc = 1'b1;
          end else begin
            state_nx = S_BODY;
          end
        end
      end
      S_BODY: o_data_ready = can_load;
      S_LAST: begin
        if (xfer) begin
          state_nx = S_IDLE;
          sent_inc = 1'b1;
        end
      end
      default: state_nx = S_IDLE;
    endcase
    word_ok = o_data_ready && i_data_valid;
    if (word_ok) begin
      load            = 1'b1;
      load_flit.ftype = (rem_q == LEN_W'(1)) ? FT_TAIL : FT_BODY;
      load_flit.data  = FLIT_DATA_W'(i_data);
      if (rem_q == LEN_W'(1)) state_nx = S_LAST;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nx;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rem_q  <= '0;
      sent_q <= '0;
      rdy_en <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
      if (state == S_IDLE && rdy_en && i_pkt_valid) rem_q <= len_c;
      else if (word_ok)                             rem_q <= rem_q - LEN_W'(1);
      if (sent_inc) sent_q <= sent_q + 16'd1;
    end
  end

  assign o_busy     = (state != S_IDLE);
  assign o_pkt_sent = sent_q;
  assign o_state    = state;

endmodule

// File: tb/tb_flit_injector.sv
// Self-checking bench for flit_injector: directed cases plus randomized packets vs a packet-level model.
module tb_flit_injector;
  import flit_injector_pkg::*;

  localparam int         ML  = 16;
  localparam logic [3:0] SRC = 4'd5;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        pkt_valid = 1'b0;
  logic        pkt_ready;
  logic [3:0]  pkt_dest = '0;
  logic [4:0]  pkt_len = '0;
  logic        data_valid = 1'b0;
  logic [31:0] data = '0;
  logic        data_ready;
  FLIT_t       flit;
  logic        req;
  logic        on_off = 1'b0;
  logic        busy;
  logic [15:0] pkt_sent;
  INJ_STATE_t  state;

  flit_injector #(.SRC_ADDR(SRC)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .i_pkt_valid    (pkt_valid),
    .o_pkt_ready    (pkt_ready),
    .i_pkt_dest     (pkt_dest),
    .i_pkt_len      (pkt_len),
    .i_data_valid   (data_valid),
    .i_data         (data),
    .o_data_ready   (data_ready),
    .o_flit         (flit),
    .o_upstream_req (req),
    .i_on_off       (on_off),
    .o_busy         (busy),
    .o_pkt_sent     (pkt_sent),
    .o_state        (state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Scoreboard state
  int          tests = 0;
  int          fails = 0;
  logic [33:0] exp_q[$];
  logic [31:0] word_q[$];
  int          on_mode = 0;
  int          rand_gaps = 0;
  int          gap_at = 0;
  int          gap_cnt = 0;
  int          consumed = 0;
  int          xfers = 0;
  int          cyc = 0;
  int          first_x = 0;
  int          last_x = 0;
  logic [15:0] sent_model = '0;
  logic        prev_hold = 1'b0;
  logic [33:0] prev_flit = '0;
  logic        prev_accept = 1'b0;
  logic [3:0]  on_pat = 4'b1001;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [33:0] mk(input int t, input logic [31:0] d);
    logic [1:0] tt;
    tt = t[1:0];
    return {tt, d};
  endfunction

  // One clock of driving, sampling and scoreboarding; returns at posedge+1.
  task automatic cycle();
    logic        x, c, a;
    logic [33:0] f, e;
    @(negedge clk);
    case (on_mode)
      0:       on_off = 1'b1;
      1:       on_off = ($urandom_range(0, 2) != 0);
      default: on_off = on_pat[cyc % 4];
    endcase
    data_valid = (word_q.size() > 0) && (gap_cnt == 0) &&
                 (rand_gaps == 0 || $urandom_range(0, 3) != 0);
    data = (word_q.size() > 0) ? word_q[0] : 32'h0;
    #1;
    if (prev_accept) check("head_latency", req, 1);
    if (prev_hold) begin
      check("hold_req", req, 1);
      check("hold_flit", flit, prev_flit);
    end
    if (req && !on_off) check("ready_while_held", data_ready, 0);
    if (gap_cnt > 0 && gap_cnt <= 2 && on_mode == 0) check("req_in_gap", req, 0);
    x = req && on_off;
    f = flit;
    c = data_valid && data_ready;
    a = pkt_valid && pkt_ready;
    prev_hold   = req && !on_off;
    prev_flit   = flit;
    prev_accept = a;
    @(posedge clk);
    #1;
    cyc++;
    if (gap_cnt > 0) gap_cnt--;
    if (x) begin
      xfers++;
      if (xfers == 1) first_x = cyc;
      last_x = cyc;
      tests++;
      assert (exp_q.size() > 0) else begin
        fails++;
        $error("FAIL extra_flit observed=%0h expected=none", f);
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("flit", f, e);
      end
    end
    if (c) begin
      void'(word_q.pop_front());
      consumed++;
      if (gap_at > 0 && consumed == gap_at) gap_cnt = 3;
    end
    if (a) pkt_valid = 1'b0;
  endtask

  // Queue one packet's expected flits and payload, then present the descriptor.
  task automatic start_pkt(input logic [3:0] dest, input int len_in, input int mode,
                           input int rgaps, input int gat, input logic [31:0] base);
    int n;
    logic [31:0] w;
    n = (len_in > ML) ? ML : len_in;
    exp_q.push_back(mk((n == 0) ? 3 : 0, (32'(dest) << 9) | (32'(SRC) << 5) | 32'(n)));
    for (int i = 0; i <= n; i++) begin
      w = (base != 0) ? base + 32'(i) : $urandom;
      word_q.push_back(w);
      if (i < n) exp_q.push_back(mk((i == n - 1) ? 2 : 1, w));
    end
    on_mode = mode; rand_gaps = rgaps; gap_at = gat;
    consumed = 0; xfers = 0; gap_cnt = 0;
    pkt_dest = dest; pkt_len = 5'(len_in); pkt_valid = 1'b1;
  endtask

  task automatic run_pkt(input logic [3:0] dest, input int len_in, input int mode,
                         input int rgaps, input int gat, input logic [31:0] base);
    int n, k;
    n = (len_in > ML) ? ML : len_in;
    start_pkt(dest, len_in, mode, rgaps, gat, base);
    k = 0;
    do begin
      cycle();
      k++;
    end while ((pkt_valid || busy || exp_q.size() > 0) && k < 600);
    tests++;
    assert (k < 600) else begin
      fails++;
      $error("FAIL pkt_timeout observed=%0d expected=<600", k);
    end
    sent_model = sent_model + 16'd1;
    check("ready_after_tail", pkt_ready, 1);
    check("pkt_sent", pkt_sent, sent_model);
    cycle();
    cycle();
    check("consumed", consumed, n);
    check("flit_count", xfers, n + 1);
    word_q.delete();
    exp_q.delete();
  endtask

  initial begin
    #12;
    check("rst_req", req, 0);
    check("rst_flit", flit, 0);
    check("rst_pkt_ready", pkt_ready, 0);
    check("rst_data_ready", data_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_pkt_sent", pkt_sent, 0);
    check("rst_state", state, 0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_reset", pkt_ready, 1);

    // Single packet at full rate: three consecutive flits
    run_pkt(4'd3, 2, 0, 0, 0, 32'hA);
    check("consecutive", last_x - first_x, 2);

    // Zero-length packet: one HEADTAIL
    run_pkt(4'd7, 0, 0, 0, 0, 32'h0);

    // on/off pattern 1,0,0,1 while sending 4 words
    run_pkt(4'd9, 4, 2, 0, 0, 32'h100);

    // Three-cycle data gap after the 2nd word
    run_pkt(4'd2, 4, 0, 0, 2, 32'h200);

    // Oversized length clamps to MAX_LEN
    run_pkt(4'd12, 20, 0, 0, 0, 32'h300);

    // Reset after the 2nd body flit
    start_pkt(4'd6, 4, 0, 0, 0, 32'h400);
    for (int k = 0; k < 50 && xfers < 3; k++) cycle();
    check("abort_point", xfers, 3);
    #1;
    reset_n = 1'b0;
    #1;
    check("arst_req", req, 0);
    check("arst_flit", flit, 0);
    check("arst_busy", busy, 0);
    check("arst_pkt_sent", pkt_sent, 0);
    check("arst_data_ready", data_ready, 0);
    exp_q.delete();
    word_q.delete();
    pkt_valid = 1'b0;
    prev_hold = 1'b0;
    prev_accept = 1'b0;
    sent_model = '0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    for (int k = 0; k < 3; k++) cycle();
    check("idle_after_reset", req, 0);
    run_pkt(4'd1, 3, 0, 0, 0, 32'h500);

    // Randomized packets with random backpressure and data gaps
    for (int p = 0; p < 25; p++)
      run_pkt(4'($urandom_range(0, 15)), $urandom_range(0, 20), 1, 1, 0, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/flit_injector.md
Name: flit_injector

Overview:
- Source-side network interface that drives one router input port.
- Accepts a packet descriptor (destination, payload length) and a payload word stream from a core.
- Segments each packet into HEAD/BODY/TAIL flits and transmits them using the router's req / on-off handshake.
- Sits between a core/traffic generator and the router's i_flit/i_upstream_req/o_on_off pins.

Parameters:
- DATA_W, 32, payload bits per flit.
- MAX_LEN, 16, maximum payload words per packet.
- LEN_W, $clog2(MAX_LEN+1), width of the length field.
- SRC_ADDR, 0, this node's PORT_ADDR_t value, carried in the head flit.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- i_pkt_valid  in  1  packet descriptor valid.
- o_pkt_ready  out  1  descriptor accepted when valid&ready.
- i_pkt_dest  in  PORT_ADDR_t  destination address.
- i_pkt_len  in  LEN_W  payload word count, 0..MAX_LEN.
- i_data_valid  in  1  payload word valid.
- i_data  in  DATA_W  payload word.
- o_data_ready  out  1  payload word consumed when valid&ready.
- o_flit  out  FLIT_t  flit to router input.
- o_upstream_req  out  1  o_flit valid; drives the router's i_upstream_req.
- i_on_off  in  1  router can accept; driven by the router's o_on_off.
- o_busy  out  1  packet in progress.
- o_pkt_sent  out  16  count of completed packets, wraps.

Behaviour:
- Reset: all outputs are 0. o_flit is all-zero, state is IDLE, counters are 0.
- Transfer rule: a flit moves on a rising edge where o_upstream_req=1 and i_on_off=1.
- Once o_upstream_req rises, it stays high and o_flit stays bit-stable until that transfer occurs.
- When i_on_off is low, the block holds its flit. No flit is dropped or duplicated.
- FSM states: IDLE, HEAD, BODY, LAST.
- IDLE:
  - o_pkt_ready=1.
  - On i_pkt_valid, latch dest and len.
  - Next cycle, present the head flit: type=HEAD, or HEADTAIL if len==0. Head fields are {dest, SRC_ADDR, len}.
  - Go to HEAD. Descriptor-to-req latency is 1 cycle.
- HEAD:
  - On transfer with len==0, go to IDLE, increment o_pkt_sent, and return to o_pkt_ready=1 in the same cycle.
  - On transfer with len>0, go to BODY.
- BODY:
  - o_data_ready = (!o_upstream_req | i_on_off). The output register is empty or draining.
  - Each accepted word loads o_flit with type=BODY, or TAIL when remaining==1, and raises req.
  - remaining decrements per accepted word. The word that takes remaining to 0 moves the FSM to LAST.
  - If no word is available, req drops after the pending transfer; bubbles are legal.
- LAST:
  - o_data_ready=0.
  - On tail transfer, go to IDLE and increment o_pkt_sent.
- o_pkt_ready is 1 only in IDLE. No descriptor is accepted mid-packet, so back-to-back packets have one idle cycle minimum after the tail.
- i_pkt_len > MAX_LEN is clamped to MAX_LEN.
- o_busy = state != IDLE.
- i_data_valid in IDLE is ignored and no word is consumed.
- o_pkt_sent wraps 0xFFFF -> 0.
- Reset asserted mid-packet: asynchronously clear all state. req drops immediately and the partial packet is abandoned (the bench checks no further flits).

Decomposition:
- router_pkg additions:
  - FLIT_TYPE_t enum {HEAD, BODY, TAIL, HEADTAIL}.
  - Head-field struct HEAD_INFO_t {dest, src, len}.
  - Injector state enum INJ_STATE_t.
  - FLIT_t is reused unchanged.
- One natural sub-module, flit_out_reg: the holding register with req/on-off hold logic. It exposes load/can_load to the FSM.

Test Plan:
- Single packet, dest=3, len=2, i_on_off=1, data 0xA, 0xB -> flits HEAD{3,SRC,2}, BODY 0xA, TAIL 0xB on three consecutive cycles; o_pkt_sent=1.
- len=0 -> exactly one HEADTAIL flit; o_pkt_ready returns to 1 on the following cycle.
- len=4, i_on_off toggled 1,0,0,1,... -> o_flit stable while off; the sequence still has exactly 5 flits with correct data order; o_data_ready=0 while held.
- Data gaps: i_data_valid low for 3 cycles mid-packet -> req low during the gap; no BODY flit is repeated; TAIL is on the 4th word.
- i_pkt_len=20 with MAX_LEN=16 -> head len=16; 16 payload words are consumed; the 17th word is not consumed.
- reset_n pulsed low after the 2nd body flit -> outputs 0 asynchronously; the next packet sends normally; o_pkt_sent=0.
